// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions N independent raw button/switch inputs. Each channel is
// synchronised, debounced, and turned into edge and long-press pulses:
//   noisy -> sync1 -> sync2 -> candidate/stability counter -> clean
//   clean -> rise / fall one-cycle pulses
//   clean -> hold counter -> long_press one-cycle pulse
//
// Parameters
//   N          number of independent channels (>= 1)
//   DELAY      cycles sync2 must stay stable before clean follows it (>= 2)
//   LONG_DELAY cycles clean must stay high before long_press fires (>= 1)
//
// Ports
//   clock       rising-edge clock for all state
//   reset       synchronous, active-high reset
//   noisy[N]    asynchronous raw input levels
//   clean[N]    debounced level (registered)
//   rise[N]     one-cycle pulse, aligned with clean going 0->1 (registered)
//   fall[N]     one-cycle pulse, aligned with clean going 1->0 (registered)
//   long_press[N] one-cycle pulse LONG_DELAY cycles into a press (registered)
//
// Latency: a held change on noisy first sampled at edge E0 shows on clean
// (and rise/fall) at edge E0+DELAY+2.
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int N          = 4,
  parameter int DELAY      = 500000,
  parameter int LONG_DELAY = 25000000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] noisy,
  output logic [N-1:0] clean,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] long_press
);

  // Stability counter only has to reach DELAY-1; hold counter reaches
  // LONG_DELAY and parks there.
  localparam int CNT_W  = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int HOLD_W = $clog2(LONG_DELAY + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DELAY - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_DELAY);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_DELAY - 1);

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser, one bit per channel. Nothing downstream looks at
  // noisy directly.
  // ---------------------------------------------------------------------------
  logic [N-1:0] sync1_q;
  logic [N-1:0] sync2_q;

  // NOTE: reset is synchronous here, so it sits inside the clocked branch and
  // the sensitivity list names only the clock edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let sync2 take the old sync1, giving
      // two real flop stages instead of a single collapsed one.
      sync1_q <= noisy;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel debounce and press timing. Each generate instance owns all of
  // its state, so channels cannot interact.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < N; i++) begin : g_chan
    logic              cand_q,  cand_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              clean_q, clean_d;
    logic              rise_q,  rise_d;
    logic              fall_q,  fall_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic              long_q,  long_d;

    always_comb begin
      // NOTE: every signal gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      clean_d = clean_q;
      hold_d  = '0;

      // Candidate tracking: any change in sync2 restarts the stability
      // count; a full count of stable cycles commits the candidate to clean.
      // The counter parks at CNT_MAX while stable, so it never wraps.
      if (sync2_q[i] != cand_q) begin
        cand_d = sync2_q[i];
        cnt_d  = '0;
      end else if (cnt_q == CNT_MAX) begin
        clean_d = cand_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end

      // Edge pulses come from the next clean value so they register on the
      // same edge that clean itself changes.
      rise_d = clean_d & ~clean_q;
      fall_d = ~clean_d & clean_q;

      // Hold timer counts cycles of registered clean high and parks at
      // HOLD_MAX, so the LONG_DELAY-1 -> LONG_DELAY step happens once per press.
      if (clean_q) begin
        hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
      end
      long_d = clean_q && (hold_q == HOLD_PRE);
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        cand_q  <= 1'b0;
        cnt_q   <= '0;
        clean_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        hold_q  <= '0;
        long_q  <= 1'b0;
      end else begin
        cand_q  <= cand_d;
        cnt_q   <= cnt_d;
        clean_q <= clean_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        hold_q  <= hold_d;
        long_q  <= long_d;
      end
    end

    assign clean[i]      = clean_q;
    assign rise[i]       = rise_q;
    assign fall[i]       = fall_q;
    assign long_press[i] = long_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed scenarios (clean step, glitch, bounce, long/short press, reset
// mid-operation) followed by random noisy traffic with occasional resets.
// Every cycle the four outputs are compared with a reference model that
// works from the sampled input history: clean takes a sampled value once
// DELAY+1 consecutive samples (lagging two edges for the synchroniser) agree,
// and long_press fires when clean has been high for exactly LONG_DELAY cycles.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int N          = 4;
  localparam int DELAY      = 4;
  localparam int LONG_DELAY = 10;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] noisy;
  logic [N-1:0] clean;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] long_press;

  always #5 clock = ~clock;

  button_conditioner #(
    .N          (N),
    .DELAY      (DELAY),
    .LONG_DELAY (LONG_DELAY)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .noisy      (noisy),
    .clean      (clean),
    .rise       (rise),
    .fall       (fall),
    .long_press (long_press)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [N-1:0] hist[$];          // hist[0] = value sampled at the latest edge
  logic [N-1:0] m_clean, m_rise, m_fall, m_long;
  int           run_len[N];       // consecutive cycles model clean has been 1

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int j = 0; j < DELAY + 3; j++) hist.push_back('0);
    m_clean = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_long  = '0;
    for (int i = 0; i < N; i++) run_len[i] = 0;
  endtask

  // Expected outputs after one rising edge, from inputs held across it.
  task automatic model_edge();
    logic [N-1:0] v, ref_v;
    logic         nc, all_eq;
    if (reset) begin
      model_reset();
    end else begin
      hist.push_front(noisy);
      void'(hist.pop_back());
      ref_v = hist[2];
      for (int i = 0; i < N; i++) begin
        all_eq = 1'b1;
        for (int j = 3; j <= 2 + DELAY; j++) begin
          v = hist[j];
          if (v[i] != ref_v[i]) all_eq = 1'b0;
        end
        nc = all_eq ? ref_v[i] : m_clean[i];
        m_long[i]  = (run_len[i] == LONG_DELAY);
        m_rise[i]  = nc & ~m_clean[i];
        m_fall[i]  = ~nc & m_clean[i];
        run_len[i] = nc ? run_len[i] + 1 : 0;
        m_clean[i] = nc;
      end
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check("clean", 32'(clean), 32'(m_clean));
    check("rise",  32'(rise),  32'(m_rise));
    check("fall",  32'(fall),  32'(m_fall));
    check("long_press", 32'(long_press), 32'(m_long));
  endtask

  initial begin
    int rise_at, rise_cnt, long_at, long_cnt, fall_at, fall_cnt, hi_cnt;
    int rise0_at, rise3_at, long3_at;
    logic [N-1:0] seen;
    int mode, thr;

    // NOTE: inputs are driven with blocking assignments just after the
    // falling edge, so they are settled well before the next rising edge.
    reset = 1'b1;
    noisy = '0;
    model_reset();
    repeat (3) step();
    check("reset_clean", 32'(clean), 32'h0);
    check("reset_pulses", 32'(rise | fall | long_press), 32'h0);

    // Reset released with quiet inputs: nothing may pulse.
    reset = 1'b0;
    step();
    check("post_reset_idle", 32'(clean | rise | fall | long_press), 32'h0);
    step();

    // Clean step on channel 0: clean at E0+6, one rise, others quiet.
    noisy[0] = 1'b1;
    repeat (6) step();
    check("step0_before", 32'(clean), 32'h0);
    step();
    check("step0_clean", 32'(clean), 32'h1);
    check("step0_rise", 32'(rise), 32'h1);
    step();
    check("step0_rise_once", 32'(rise), 32'h0);

    // Glitch of 3 cycles on channel 1 never reaches clean.
    seen = '0;
    noisy[1] = 1'b1;
    repeat (3) begin step(); seen |= clean | rise | fall; end
    noisy[1] = 1'b0;
    repeat (12) begin step(); seen |= clean | rise | fall; end
    check("glitch1_quiet", 32'(seen & 4'b0010), 32'h0);

    // Bounce on channel 2, settling high; last toggle sampled at c=8.
    rise_cnt = 0; rise_at = -1;
    for (int c = 0; c < 30; c++) begin
      noisy[2] = (c < 10) ? (((c / 2) % 2) == 0) : 1'b1;
      step();
      if (rise[2]) begin
        rise_cnt++;
        if (rise_at < 0) rise_at = c;
      end
    end
    check("bounce2_rises", 32'(rise_cnt), 32'd1);
    check("bounce2_latency", 32'(rise_at), 32'd14);

    // Long press on channel 3, then release.
    rise_at = -1; long_at = -1; long_cnt = 0;
    noisy[3] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (rise[3] && rise_at < 0) rise_at = c;
      if (long_press[3]) begin long_cnt++; long_at = c; end
    end
    check("long3_rise_at", 32'(rise_at), 32'd6);
    check("long3_at", 32'(long_at), 32'd16);
    check("long3_once", 32'(long_cnt), 32'd1);
    fall_at = -1; fall_cnt = 0;
    noisy[3] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (fall[3]) begin fall_cnt++; fall_at = c; end
    end
    check("release3_fall_at", 32'(fall_at), 32'd6);
    check("release3_falls", 32'(fall_cnt), 32'd1);

    // Short press on channel 0: clean high 5 cycles, no long_press.
    noisy[0] = 1'b0;
    repeat (10) step();
    rise_cnt = 0; fall_cnt = 0; long_cnt = 0; hi_cnt = 0;
    for (int c = 0; c < 25; c++) begin
      noisy[0] = (c < 5);
      step();
      if (rise[0]) rise_cnt++;
      if (fall[0]) fall_cnt++;
      if (long_press[0]) long_cnt++;
      if (clean[0]) hi_cnt++;
    end
    check("short0_rises", 32'(rise_cnt), 32'd1);
    check("short0_falls", 32'(fall_cnt), 32'd1);
    check("short0_no_long", 32'(long_cnt), 32'd0);
    check("short0_high_cycles", 32'(hi_cnt), 32'd5);

    // Reset mid-operation: channel 0 counting (cnt=2), channel 3 mid-press
    // (hold=7). Afterwards latencies restart from the first post-reset edge.
    noisy[3] = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c == 9) noisy[0] = 1'b1;
      step();
    end
    check("pre_reset_press3", 32'(clean & 4'b1001), 32'h8);
    reset = 1'b1;
    step();
    check("midreset_clean", 32'(clean), 32'h0);
    check("midreset_pulses", 32'(rise | fall | long_press), 32'h0);
    reset = 1'b0;
    rise0_at = -1; rise3_at = -1; long3_at = -1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (c == 0) check("after_reset_quiet", 32'(clean | rise | fall | long_press), 32'h0);
      if (rise[0] && rise0_at < 0) rise0_at = c;
      if (rise[3] && rise3_at < 0) rise3_at = c;
      if (long_press[3] && long3_at < 0) long3_at = c;
    end
    check("restart0_rise_at", 32'(rise0_at), 32'd6);
    check("restart3_rise_at", 32'(rise3_at), 32'd6);
    check("restart3_long_at", 32'(long3_at), 32'd16);

    // Random traffic in blocks of differing bounce rates, rare resets.
    for (int blk = 0; blk < 24; blk++) begin
      mode = $urandom_range(0, 2);
      thr  = (mode == 0) ? 50 : (mode == 1) ? 16 : 2;
      for (int c = 0; c < 100; c++) begin
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 99) < thr) noisy[i] = ~noisy[i];
        end
        reset = ($urandom_range(0, 299) == 0);
        step();
      end
    end
    reset = 1'b0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
